// File: rtl/flight_mode_controller_if.sv
// Command handshake between the flight command source and the flight mode controller.
interface flight_mode_controller_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/flight_mode_controller.sv
// Flight command sequencer: drives the one-hot velocity/position selects for the axis
// datapath, sequences warp jumps (charge, warp, cooldown) and bounds stealth duration.
module flight_mode_controller #(
  parameter int WARP_CHARGE   = 8,
  parameter int WARP_COOLDOWN = 16,
  parameter int STEALTH_LIMIT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  flight_mode_controller_if.slave   cmd_bus,
  output logic [3:0]                mode_selector,
  output logic [3:0]                pos_selector,
  output logic                      warp_busy,
  output logic                      cmd_reject,
  output logic                      stealth_timeout
);

  localparam int PH_MAX = (WARP_CHARGE > WARP_COOLDOWN) ? WARP_CHARGE : WARP_COOLDOWN;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int ST_W   = $clog2(STEALTH_LIMIT);

  localparam logic [PH_W-1:0] CHARGE_LOAD = PH_W'(WARP_CHARGE - 1);
  localparam logic [PH_W-1:0] COOL_LOAD   = PH_W'(WARP_COOLDOWN - 1);
  localparam logic [ST_W-1:0] ST_LAST     = ST_W'(STEALTH_LIMIT - 1);

  localparam logic [3:0] MODE_STOP    = 4'b0001;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;
  localparam logic [3:0] POS_ZERO     = 4'b0001;
  localparam logic [3:0] POS_NORMAL   = 4'b0010;
  localparam logic [3:0] POS_WARP     = 4'b0100;

  typedef enum logic [2:0] {INIT, CRUISE, CHARGE, WARP, COOLDOWN} state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      mode_q, mode_d;
  logic [ST_W-1:0] stealth_cnt_q, stealth_cnt_d;
  logic [3:0]      mode_sel_q, mode_sel_d;
  logic [3:0]      pos_sel_q, pos_sel_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            reject_q, reject_d;
  logic            timeout_q, timeout_d;
  logic            accept, mode_cmd, in_stealth, limit_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT;
      phase_q       <= '0;
      mode_q        <= MODE_STOP;
      stealth_cnt_q <= '0;
      mode_sel_q    <= MODE_STOP;
      pos_sel_q     <= POS_ZERO;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      reject_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      mode_q        <= mode_d;
      stealth_cnt_q <= stealth_cnt_d;
      mode_sel_q    <= mode_sel_d;
      pos_sel_q     <= pos_sel_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      reject_q      <= reject_d;
      timeout_q     <= timeout_d;
    end
  end

  // cmd_ready is only high in CRUISE/COOLDOWN, so accept implies one of those states
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    mode_d        = mode_q;
    stealth_cnt_d = stealth_cnt_q;
    accept        = cmd_bus.cmd_valid & ready_q;
    mode_cmd      = accept && (cmd_bus.cmd <= 3'd3);
    in_stealth    = (mode_sel_q == MODE_STEALTH);
    limit_hit     = in_stealth && (stealth_cnt_q == ST_LAST) && !mode_cmd;
    reject_d      = accept && (((state_q == CRUISE) && (cmd_bus.cmd >= 3'd5)) ||
                               ((state_q == COOLDOWN) && (cmd_bus.cmd >= 3'd4)));
    timeout_d     = limit_hit;

    unique case (state_q)
      INIT:   state_d = CRUISE;
      CRUISE: begin
        if (accept && (cmd_bus.cmd == 3'd4)) begin
          state_d = CHARGE;
          phase_d = CHARGE_LOAD;
        end
      end
      CHARGE: begin
        if (phase_q == '0) state_d = WARP;
        else               phase_d = phase_q - PH_W'(1);
      end
      WARP: begin
        state_d = COOLDOWN;
        phase_d = COOL_LOAD;
      end
      COOLDOWN: begin
        if (phase_q == '0) state_d = CRUISE;
        else               phase_d = phase_q - PH_W'(1);
      end
      default: state_d = INIT;
    endcase

    if (mode_cmd)       mode_d = MODE_STOP << cmd_bus.cmd[1:0];
    else if (limit_hit) mode_d = MODE_DEFENSE;

    if (limit_hit || (mode_cmd && (cmd_bus.cmd == 3'd3))) stealth_cnt_d = '0;
    else if (in_stealth)                                  stealth_cnt_d = stealth_cnt_q + ST_W'(1);
    else                                                  stealth_cnt_d = '0;
  end

  // Outputs are decoded from the next state so they land in the same cycle as the state
  always_comb begin
    mode_sel_d = MODE_STOP;
    pos_sel_d  = POS_ZERO;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    unique case (state_d)
      INIT: ;
      CRUISE: begin
        mode_sel_d = mode_d;
        pos_sel_d  = POS_NORMAL;
        ready_d    = 1'b1;
      end
      CHARGE: begin
        pos_sel_d = POS_NORMAL;
        busy_d    = 1'b1;
      end
      WARP: begin
        pos_sel_d = POS_WARP;
        busy_d    = 1'b1;
      end
      COOLDOWN: begin
        mode_sel_d = mode_d;
        pos_sel_d  = POS_NORMAL;
        ready_d    = 1'b1;
        busy_d     = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_bus.cmd_ready = ready_q;
  assign mode_selector     = mode_sel_q;
  assign pos_selector      = pos_sel_q;
  assign warp_busy         = busy_q;
  assign cmd_reject        = reject_q;
  assign stealth_timeout   = timeout_q;

endmodule

// File: tb/tb_flight_mode_controller.sv
// Bench for flight_mode_controller: directed scenarios plus random commands against a timeline model.
module tb_flight_mode_controller;
  localparam int C  = 8;
  localparam int CD = 16;
  localparam int L  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mode_selector, pos_selector;
  logic       warp_busy, cmd_reject, stealth_timeout;

  flight_mode_controller_if bus();

  flight_mode_controller #(.WARP_CHARGE(C), .WARP_COOLDOWN(CD), .STEALTH_LIMIT(L)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_bus         (bus),
    .mode_selector   (mode_selector),
    .pos_selector    (pos_selector),
    .warp_busy       (warp_busy),
    .cmd_reject      (cmd_reject),
    .stealth_timeout (stealth_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: boot flag, commanded mode (0..3), cycles since warp accepted (0 = none),
  // stealth cycles already shown in the current run, and pending one-cycle pulses.
  bit m_boot = 1'b1;
  int m_mode = 0;
  int m_age  = 0;
  int m_run  = 0;
  bit m_rej  = 1'b0;
  bit m_to   = 1'b0;

  function automatic logic [11:0] model_exp();
    logic [3:0] m, p;
    logic rdy, bsy;
    if (m_boot) begin
      m = 4'b0001; p = 4'b0001; rdy = 1'b0; bsy = 1'b0;
    end else if (m_age >= 1 && m_age <= C) begin
      m = 4'b0001; p = 4'b0010; rdy = 1'b0; bsy = 1'b1;
    end else if (m_age == C + 1) begin
      m = 4'b0001; p = 4'b0100; rdy = 1'b0; bsy = 1'b1;
    end else begin
      m = 4'b0001 << m_mode; p = 4'b0010; rdy = 1'b1; bsy = (m_age != 0);
    end
    return {m, p, rdy, bsy, m_rej, m_to};
  endfunction

  function automatic logic [11:0] actual();
    return {mode_selector, pos_selector, bus.cmd_ready, warp_busy, cmd_reject, stealth_timeout};
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [2:0] c);
    logic [11:0] e;
    bit rdy, charging, cruise, stealth_now, acc, modecmd;
    e           = model_exp();
    rdy         = e[3];
    charging    = (m_age >= 1) && (m_age <= C + 1);
    cruise      = !m_boot && (m_age == 0);
    stealth_now = !m_boot && !charging && (m_mode == 3);
    if (r) begin
      m_boot = 1'b1; m_mode = 0; m_age = 0; m_run = 0; m_rej = 1'b0; m_to = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_run = 0; m_rej = 1'b0; m_to = 1'b0;
    end else begin
      acc     = v && rdy;
      modecmd = acc && (c <= 3);
      m_rej   = acc && (cruise ? (c >= 5) : (c >= 4));
      m_to    = 1'b0;
      if (stealth_now && (m_run == L - 1) && !modecmd) begin
        m_to = 1'b1; m_mode = 2; m_run = 0;
      end else if (modecmd) begin
        m_mode = int'(c); m_run = 0;
      end else begin
        m_run = stealth_now ? m_run + 1 : 0;
      end
      if (acc && cruise && (c == 3'd4)) m_age = 1;
      else if (m_age == C + CD + 1)     m_age = 0;
      else if (m_age > 0)               m_age = m_age + 1;
    end
  endtask

  task automatic drive_cycle(input bit r, input bit v, input logic [2:0] c);
    reset         = r;
    bus.cmd_valid = v;
    bus.cmd       = c;
    model_step(r, v, c);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, actual(), model_exp());
      end
      drive_cycle(1'b1, 1'b0, 3'd0);
    end
    n_tests++;
    if ({mode_selector, pos_selector, bus.cmd_ready, warp_busy, cmd_reject, stealth_timeout} !== 12'b0001_0001_0000) begin
      n_fail++; $display("FAIL reset_init got=%b want=000100010000", actual());
    end
    drive_cycle(1'b0, 1'b0, 3'd0);
    n_tests++;
    if ({mode_selector, pos_selector, bus.cmd_ready, warp_busy} !== 10'b0001_0010_10) begin
      n_fail++; $display("FAIL reset_cruise got=%b want=0001001010", actual());
    end
    drive_cycle(1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_mode_cmds();
    logic [2:0] c;
    bit v;
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL mode_model cyc=%0d k=%0d got=%b want=%b", cyc, k, actual(), model_exp());
      end
      if (k >= 1 && k <= 4) begin
        n_tests++;
        if (mode_selector !== (k == 1 ? 4'b0010 : k == 2 ? 4'b0100 : 4'b1000)) begin
          n_fail++; $display("FAIL mode_cmd k=%0d got=%b", k, mode_selector);
        end
      end
      if (k == 4 || k == 5) begin
        n_tests++;
        if (cmd_reject !== (k == 4)) begin
          n_fail++; $display("FAIL mode_reject k=%0d got=%b want=%b", k, cmd_reject, (k == 4));
        end
      end
      v = (k <= 3);
      c = (k == 3) ? 3'd6 : 3'(k + 1);
      drive_cycle(1'b0, v, c);
    end
  endtask

  task automatic test_warp();
    logic [9:0] want;
    bit have;
    int warps = 0;
    n_tests++;
    if (actual() !== model_exp()) begin
      n_fail++; $display("FAIL warp_pre got=%b want=%b", actual(), model_exp());
    end
    drive_cycle(1'b0, 1'b1, 3'd1);
    for (int k = 0; k <= 28; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL warp_model cyc=%0d k=%0d got=%b want=%b", cyc, k, actual(), model_exp());
      end
      if (pos_selector == 4'b0100) warps++;
      have = 1'b1;
      case (k)
        1, 8:    want = 10'b0001_0010_01;
        9:       want = 10'b0001_0100_01;
        10, 25:  want = 10'b0010_0010_11;
        26:      want = 10'b0010_0010_10;
        default: begin want = '0; have = 1'b0; end
      endcase
      if (have) begin
        n_tests++;
        if ({mode_selector, pos_selector, bus.cmd_ready, warp_busy} !== want) begin
          n_fail++; $display("FAIL warp_timeline k=%0d got=%b want=%b", k,
                             {mode_selector, pos_selector, bus.cmd_ready, warp_busy}, want);
        end
      end
      drive_cycle(1'b0, (k == 0), 3'd4);
    end
    n_tests++;
    if (warps != 1) begin
      n_fail++; $display("FAIL warp_count got=%0d want=1", warps);
    end
  endtask

  task automatic test_cooldown();
    int warps = 0;
    bit v;
    logic [2:0] c;
    for (int k = 0; k <= 30; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL cool_model cyc=%0d k=%0d got=%b want=%b", cyc, k, actual(), model_exp());
      end
      if (pos_selector == 4'b0100) warps++;
      if (k == 13) begin
        n_tests++;
        if (cmd_reject !== 1'b1) begin n_fail++; $display("FAIL cool_reject got=%b want=1", cmd_reject); end
      end
      if (k == 15) begin
        n_tests++;
        if (mode_selector !== 4'b0100) begin n_fail++; $display("FAIL cool_mode got=%b want=0100", mode_selector); end
      end
      if (k == 25 || k == 26) begin
        n_tests++;
        if ({bus.cmd_ready, warp_busy} !== {1'b1, (k == 25)}) begin
          n_fail++; $display("FAIL cool_exit k=%0d got=%b%b", k, bus.cmd_ready, warp_busy);
        end
      end
      v = (k == 0 || k == 12 || k == 14);
      c = (k == 14) ? 3'd2 : 3'd4;
      drive_cycle(1'b0, v, c);
    end
    n_tests++;
    if (warps != 1) begin n_fail++; $display("FAIL cool_warp_count got=%0d want=1", warps); end
  endtask

  task automatic test_stealth();
    int shown = 0;
    for (int k = 0; k <= 8; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL stealth_model cyc=%0d k=%0d got=%b want=%b", cyc, k, actual(), model_exp());
      end
      if (mode_selector == 4'b1000) shown++;
      if (k == 5 || k == 6) begin
        n_tests++;
        if ({stealth_timeout, mode_selector} !== {(k == 5), 4'b0100}) begin
          n_fail++; $display("FAIL stealth_timeout k=%0d got=%b/%b", k, stealth_timeout, mode_selector);
        end
      end
      drive_cycle(1'b0, (k == 0), 3'd3);
    end
    n_tests++;
    if (shown != L) begin n_fail++; $display("FAIL stealth_len got=%0d want=%0d", shown, L); end
    for (int k = 0; k <= 7; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL stealth_win_model cyc=%0d k=%0d got=%b want=%b", cyc, k, actual(), model_exp());
      end
      if (k >= 4 && k <= 6) begin
        n_tests++;
        if ({stealth_timeout, mode_selector} !== {1'b0, (k == 4 ? 4'b1000 : 4'b0010)}) begin
          n_fail++; $display("FAIL stealth_cmd_wins k=%0d got=%b/%b", k, stealth_timeout, mode_selector);
        end
      end
      drive_cycle(1'b0, (k == 0 || k == 4), (k == 0) ? 3'd3 : 3'd1);
    end
  endtask

  task automatic test_reset_mid_warp();
    int warps = 0;
    for (int k = 0; k <= 30; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL midwarp_model cyc=%0d k=%0d got=%b want=%b", cyc, k, actual(), model_exp());
      end
      if (pos_selector == 4'b0100) warps++;
      if (k == 4 || k == 5) begin
        n_tests++;
        if ({mode_selector, pos_selector, bus.cmd_ready, warp_busy} !==
            (k == 4 ? 10'b0001_0001_00 : 10'b0001_0010_10)) begin
          n_fail++; $display("FAIL midwarp_reset k=%0d got=%b", k,
                             {mode_selector, pos_selector, bus.cmd_ready, warp_busy});
        end
      end
      drive_cycle((k == 3), (k == 0), 3'd4);
    end
    n_tests++;
    if (warps != 0) begin n_fail++; $display("FAIL midwarp_no_warp got=%0d want=0", warps); end
  endtask

  task automatic test_random();
    bit r, v;
    logic [2:0] c;
    for (int k = 0; k < 800; k++) begin
      n_tests++;
      if (actual() !== model_exp()) begin
        n_fail++; $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, actual(), model_exp());
      end
      n_tests++;
      if (!$onehot(mode_selector) || !$onehot(pos_selector) || pos_selector == 4'b1000) begin
        n_fail++; $display("FAIL random_onehot cyc=%0d got=%b/%b", cyc, mode_selector, pos_selector);
      end
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      if (c == 3'd4 && $urandom_range(0, 2) != 0) c = 3'd0;
      drive_cycle(r, v, c);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    test_reset();
    test_mode_cmds();
    test_warp();
    test_cooldown();
    test_stealth();
    test_reset_mid_warp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/flight_mode_controller.md
# flight_mode_controller

Upstream sequencer for the per-axis position datapath. Accepts flight commands over a valid/ready handshake and drives the one-hot `mode_selector` (velocity select) and `pos_selector` (position-update select) buses consumed by the axis/spacial position stages. It also sequences a warp jump as charge → single-cycle warp → cooldown, and enforces a stealth time limit.

## Interface
- `WARP_CHARGE`, default 8: number of CHARGE cycles before the warp cycle; must be ≥1.
- `WARP_COOLDOWN`, default 16: number of COOLDOWN cycles after the warp cycle; must be ≥1.
- `STEALTH_LIMIT`, default 32: maximum consecutive cycles with stealth mode on the output; must be ≥2.
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd`  in  3  command code: 0 stop, 1 attack, 2 defense, 3 stealth, 4 warp, 5–7 illegal.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `mode_selector`  out  4  one-hot velocity select: 0001 stop, 0010 attack, 0100 defense, 1000 stealth.
- `pos_selector`  out  4  one-hot position select: 0001 reset-to-zero, 0010 normal (pos+vel), 0100 warp; 1000 is never driven.
- `warp_busy`  out  1  high in CHARGE, WARP and COOLDOWN.
- `cmd_reject`  out  1  one-cycle pulse for an accepted but refused command.
- `stealth_timeout`  out  1  one-cycle pulse when stealth is forcibly ended.

## Operation
- All outputs are registered. A command is accepted when `cmd_valid & cmd_ready`.
- Internal state: FSM {INIT, CRUISE, CHARGE, WARP, COOLDOWN}; `mode_reg` (one-hot, 4 bits); phase counter; stealth counter.
- Reset, from any state including mid-warp:
  - Next state is INIT.
  - `mode_reg` = 0001; both counters = 0.
  - Outputs: `mode_selector`=0001, `pos_selector`=0001, `cmd_ready`=0, `warp_busy`=0, `cmd_reject`=0, `stealth_timeout`=0.
- INIT (exactly 1 cycle):
  - Outputs `mode_selector`=0001, `pos_selector`=0001, `cmd_ready`=0.
  - Next state is CRUISE.
- CRUISE:
  - Outputs `pos_selector`=0010, `mode_selector`=`mode_reg`, `cmd_ready`=1.
  - Accepted cmd 0–3 loads `mode_reg`.
  - Accepted cmd 4 goes to CHARGE with the phase counter = WARP_CHARGE-1.
  - Accepted cmd 5–7 pulses `cmd_reject`; no other change.
- CHARGE:
  - Outputs `mode_selector`=0001 (hold still), `pos_selector`=0010, `cmd_ready`=0.
  - The phase counter decrements each cycle; at 0 the next state is WARP.
- WARP (exactly 1 cycle):
  - Outputs `mode_selector`=0001, `pos_selector`=0100, `cmd_ready`=0.
  - Next state is COOLDOWN with the phase counter = WARP_COOLDOWN-1.
- COOLDOWN:
  - Outputs `pos_selector`=0010, `mode_selector`=`mode_reg` (the pre-warp mode is restored), `cmd_ready`=1.
  - Accepted cmd 0–3 loads `mode_reg`.
  - Accepted cmd 4–7 pulses `cmd_reject`.
  - The phase counter decrements; at 0 the next state is CRUISE.
- Stealth limit:
  - The stealth counter increments on every cycle where the registered `mode_selector`=1000; it clears otherwise.
  - If the counter equals STEALTH_LIMIT-1 and no mode-changing command is accepted that cycle, then:
    - `mode_reg` becomes 0100;
    - `stealth_timeout` pulses;
    - the counter clears.
- Simultaneous events:
  - An accepted cmd 0–2 at the limit cycle wins, with no timeout pulse.
  - An accepted cmd 3 while already in stealth reloads stealth and clears the counter, with no timeout pulse.
- `mode_reg` is never written in CHARGE or WARP.

## Timing
- A command accepted at cycle N takes effect on the outputs at N+1.
- Reset released after cycle R: INIT at R+1, CRUISE (`cmd_ready`=1) at R+2.
- Warp accepted at N:
  - CHARGE at N+1 … N+WARP_CHARGE.
  - WARP at N+WARP_CHARGE+1.
  - COOLDOWN at N+WARP_CHARGE+2 … N+WARP_CHARGE+WARP_COOLDOWN+1.
  - CRUISE at N+WARP_CHARGE+WARP_COOLDOWN+2.
- `pos_selector`=0100 is asserted for exactly one cycle per warp.
- `cmd_reject` and `stealth_timeout` are asserted in cycle N+1 for the triggering cycle N.
- Stealth output held continuously: `mode_selector`=1000 for exactly STEALTH_LIMIT cycles, then 0100.
- Invariant: `mode_selector` and `pos_selector` are always exactly one-hot.

## Test plan
- **Reset and boot.** Hold `reset` for 3 cycles, then release.
  - INIT for 1 cycle with 0001/0001.
  - Next cycle: `pos_selector`=0010, `mode_selector`=0001, `cmd_ready`=1.
- **Mode commands.** In CRUISE, send cmd 1, 2, 3 on consecutive cycles.
  - `mode_selector` reads 0010, 0100, 1000 one cycle after each command.
  - Send cmd 6: `cmd_reject` pulses for one cycle and the mode stays 1000.
- **Warp sequence (defaults).** Set mode to attack, then send cmd 4 at N.
  - Outputs 0001/0010 for 8 cycles.
  - 0001/0100 at N+9.
  - COOLDOWN with 0010/0010 for 16 cycles; `warp_busy` high throughout.
  - CRUISE at N+26.
- **Cooldown rules.** During COOLDOWN, send cmd 4: `cmd_reject` pulses and there is no second warp. Send cmd 2: `mode_selector`=0100 next cycle, and CRUISE is still entered on schedule.
- **Stealth limit (STEALTH_LIMIT=4).**
  - Send cmd 3: stealth shows for 4 cycles, then 0100 with a one-cycle `stealth_timeout` pulse.
  - Repeat, sending cmd 1 on the limit cycle: attack is applied and there is no timeout pulse.
- **Reset mid-warp.** Assert `reset` during CHARGE cycle 3: the next cycle shows 0001/0001, `warp_busy`=0, and no WARP cycle ever appears.
